// File: rtl/vga_pkg.sv
// Shared VGA types, widths and the decimal digit font.
package vga_pkg;

    localparam int unsigned HCW  = 11;
    localparam int unsigned VCW  = 11;
    localparam int unsigned RGBW = 12;

    // One pixel worth of VGA timing plus colour.
    typedef struct packed {
        logic [VCW-1:0]  vcount;
        logic            vsync;
        logic            vblnk;
        logic [HCW-1:0]  hcount;
        logic            hsync;
        logic            hblnk;
        logic [RGBW-1:0] rgb;
    } vga_t;

    // 8x16 glyphs for '0'..'9', MSB is the leftmost pixel.
    localparam logic [7:0] DIGIT_FONT [10][16] = '{
        '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h60,8'h66,8'h7E,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h06,8'h06,8'h1C,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h7E,8'h60,8'h60,8'h60,8'h7C,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h1C,8'h30,8'h60,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h7E,8'h66,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h3E,8'h06,8'h06,8'h06,8'h0C,8'h78,8'h00,8'h00,8'h00,8'h00}
    };

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between drawing stages.
interface vga_if;
    import vga_pkg::*;

    logic [VCW-1:0]  vcount;
    logic            vsync;
    logic            vblnk;
    logic [HCW-1:0]  hcount;
    logic            hsync;
    logic            hblnk;
    logic [RGBW-1:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_score.sv
// Overlays a two-digit score at a fixed position; the score is latched once
// per frame and flashes after every increase. Fixed 2-cycle latency.
module draw_score
    import vga_pkg::*;
#(
    parameter int unsigned   XPOS         = 16,
    parameter int unsigned   YPOS         = 16,
    parameter int unsigned   SCALE_LOG2   = 1,
    parameter logic [11:0]   TEXT_COLOR   = 12'hFFF,
    parameter logic [11:0]   FLASH_COLOR  = 12'hF00,
    parameter int unsigned   FLASH_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    vga_if.in          score_in,
    vga_if.out         score_out,
    input  logic [4:0] points
);

    localparam int unsigned    W          = 8 << SCALE_LOG2;
    localparam int unsigned    H          = 16 << SCALE_LOG2;
    localparam logic [HCW-1:0] X_LO       = HCW'(XPOS);
    localparam logic [HCW-1:0] X_HI       = HCW'(XPOS + 2 * W);
    localparam logic [VCW-1:0] Y_LO       = VCW'(YPOS);
    localparam logic [VCW-1:0] Y_HI       = VCW'(YPOS + H);
    localparam logic [7:0]     FLASH_LOAD = 8'(FLASH_FRAMES);

    // Latched score and flash state
    logic       vblnk_prev_q, vblnk_prev_d;
    logic [1:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic [4:0] pts_q, pts_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;

    // Pipeline registers
    vga_t       s1_q, s1_d;
    logic       draw1_q, draw1_d;
    logic [3:0] row1_q, row1_d;
    logic [2:0] bit1_q, bit1_d;
    logic [3:0] digit1_q, digit1_d;
    vga_t       s2_q, s2_d;

    logic [HCW-1:0] dx_c;
    logic [VCW-1:0] dy_c;
    logic [3:0]     col_c;
    logic           in_field_c;
    logic [7:0]     font_row_c;
    logic [11:0]    color_c;

    // Frame latch: sample points on a vblnk rising edge and update the flash counter
    always_comb begin
        vblnk_prev_d = score_in.vblnk;
        tens_d       = tens_q;
        units_d      = units_q;
        pts_d        = pts_q;
        flash_cnt_d  = flash_cnt_q;
        if (score_in.vblnk && !vblnk_prev_q) begin
            tens_d  = 2'(points / 5'd10);
            units_d = 4'(points % 5'd10);
            pts_d   = points;
            if (points > pts_q) begin
                flash_cnt_d = FLASH_LOAD;
            end else if (flash_cnt_q != 8'd0) begin
                flash_cnt_d = flash_cnt_q - 8'd1;
            end
        end
    end

    // Stage 1: field geometry, glyph coordinates and digit selection
    always_comb begin
        dx_c       = '0;
        dy_c       = '0;
        in_field_c = 1'b0;
        if (score_in.hcount >= X_LO && score_in.hcount < X_HI &&
            score_in.vcount >= Y_LO && score_in.vcount < Y_HI) begin
            in_field_c = 1'b1;
            dx_c       = score_in.hcount - X_LO;
            dy_c       = score_in.vcount - Y_LO;
        end
        col_c    = 4'(dx_c >> SCALE_LOG2);
        row1_d   = 4'(dy_c >> SCALE_LOG2);
        bit1_d   = 3'(3'd7 - col_c[2:0]);
        digit1_d = col_c[3] ? units_q : {2'b00, tens_q};
        // tens digit is transparent when it would be a leading zero
        draw1_d  = in_field_c && !score_in.vblnk && !score_in.hblnk &&
                   !(!col_c[3] && tens_q == 2'd0);

        s1_d.vcount = score_in.vcount;
        s1_d.vsync  = score_in.vsync;
        s1_d.vblnk  = score_in.vblnk;
        s1_d.hcount = score_in.hcount;
        s1_d.hsync  = score_in.hsync;
        s1_d.hblnk  = score_in.hblnk;
        s1_d.rgb    = score_in.rgb;
    end

    // Stage 2: font lookup and colour multiplex
    always_comb begin
        font_row_c = DIGIT_FONT[digit1_q][row1_q];
        color_c    = (flash_cnt_q != 8'd0 && flash_cnt_q[2]) ? FLASH_COLOR : TEXT_COLOR;
        s2_d       = s1_q;
        if (draw1_q && font_row_c[bit1_q]) begin
            s2_d.rgb = color_c;
        end
    end

    // All state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            tens_q       <= '0;
            units_q      <= '0;
            pts_q        <= '0;
            flash_cnt_q  <= '0;
            s1_q         <= '0;
            draw1_q      <= 1'b0;
            row1_q       <= '0;
            bit1_q       <= '0;
            digit1_q     <= '0;
            s2_q         <= '0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            pts_q        <= pts_d;
            flash_cnt_q  <= flash_cnt_d;
            s1_q         <= s1_d;
            draw1_q      <= draw1_d;
            row1_q       <= row1_d;
            bit1_q       <= bit1_d;
            digit1_q     <= digit1_d;
            s2_q         <= s2_d;
        end
    end

    assign score_out.vcount = s2_q.vcount;
    assign score_out.vsync  = s2_q.vsync;
    assign score_out.vblnk  = s2_q.vblnk;
    assign score_out.hcount = s2_q.hcount;
    assign score_out.hsync  = s2_q.hsync;
    assign score_out.hblnk  = s2_q.hblnk;
    assign score_out.rgb    = s2_q.rgb;

endmodule
